// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART echo buffer: the default byte width and the
// drain-state encoding used by the transmit scheduler.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Byte width shared by the receiver, the buffer and the transmitter.
    localparam int UART_DATA_WIDTH = 8;

    // Drain scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } drain_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock byte FIFO. A write is taken when the FIFO is not full, or when
// it is full but a read happens in the same cycle. Level is exact (no wrap).
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset (pointers/level/flags)
//   wr_en_i    in   write request
//   wr_data_i  in   write data
//   rd_en_i    in   read request (ignored while empty)
//   rd_data_o  out  head entry (valid while not empty)
//   level_o    out  stored entries, 0..DEPTH
//   full_o     out  level == DEPTH
//   empty_o    out  level == 0
//   drop_o     out  write request rejected this cycle
// -----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, empty_q;
    logic                  wr_fire_s, rd_fire_s;

    // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
    assign rd_fire_s = rd_en_i && !empty_q;
    assign wr_fire_s = wr_en_i && (!full_q || rd_fire_s);
    assign drop_o    = wr_en_i && full_q && !rd_fire_s;

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

    // Next-state for pointers and level; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_fire_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_fire_s, rd_fire_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control registers: pointers, level and the registered full/empty flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == LVL_W'(DEPTH));
            empty_q  <= (level_d == '0);
        end
    end

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// -----------------------------------------------------------------------------
// uart_echo_buffer
// Queues every byte from the UART receiver and replays it to the transmitter,
// one byte per transmitter busy window. hold pauses new launches.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   rx_byte        in   received byte (valid with rx_valid)
//   rx_valid       in   single-cycle receive strobe
//   hold           in   1 = do not start a new transmission
//   tx_busy        in   transmitter busy flag
//   tx_byte        out  byte presented to the transmitter (registered)
//   tx_data_valid  out  single-cycle launch strobe (registered)
//   level          out  number of stored bytes
//   full           out  level == DEPTH
//   empty          out  level == 0
//   overflow       out  pulse, cycle after a dropped byte
//   drop_count     out  dropped bytes, saturating at 255
// -----------------------------------------------------------------------------
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    rx_byte,
    input  logic                     rx_valid,
    input  logic                     hold,
    input  logic                     tx_busy,
    output logic [DATA_WIDTH-1:0]    tx_byte,
    output logic                     tx_data_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    // Last count value spent in WAIT_BUSY; the wait lasts BUSY_TIMEOUT cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

    drain_state_e          state_q, state_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_q, drop_d;

    logic [DATA_WIDTH-1:0] head_s;
    logic [LVL_W-1:0]      level_s;
    logic                  full_s, empty_s, drop_s, rd_en_s;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (rx_valid),
        .wr_data_i (rx_byte),
        .rd_en_i   (rd_en_s),
        .rd_data_o (head_s),
        .level_o   (level_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .drop_o    (drop_s)
    );

    assign tx_byte       = tx_byte_q;
    assign tx_data_valid = tx_valid_q;
    assign level         = level_s;
    assign full          = full_s;
    assign empty         = empty_s;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

    // Drain scheduler next-state; the launch strobe is registered out of LOAD
    // so it is high exactly during LAUNCH.
    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        tx_byte_d  = tx_byte_q;
        tx_valid_d = 1'b0;
        rd_en_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s && !hold && !tx_busy) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                rd_en_s    = 1'b1;
                tx_byte_d  = head_s;
                tx_valid_d = 1'b1;
                state_d    = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // An abandoned wait counts the byte as sent; it is not retried.
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Overflow pulse and saturating drop counter next-state.
    always_comb begin
        overflow_d = drop_s;
        drop_d     = drop_q;
        if (drop_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State, timeout counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            tx_byte_q  <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            tx_byte_q  <= tx_byte_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

endmodule
